// File: rtl/food_manager.sv
// Food placement controller for the snake game: detects eating, requests new
// coordinates, clamps/snaps them to the grid and checks them against the snake body.
module food_manager #(
    parameter int GRID_LOG2 = 4,
    parameter int X_MIN     = 16,
    parameter int X_MAX     = 608,
    parameter int Y_MIN     = 16,
    parameter int Y_MAX     = 448,
    parameter int MAX_RETRY = 8
) (
    input  logic       I_clk,
    input  logic       I_rst_n,
    input  logic [9:0] I_head_x,
    input  logic [9:0] I_head_y,
    input  logic       I_head_valid,
    input  logic [9:0] I_rand_x,
    input  logic [9:0] I_rand_y,
    output logic       O_drive,
    output logic       O_query_req,
    output logic [9:0] O_query_x,
    output logic [9:0] O_query_y,
    input  logic       I_query_ack,
    input  logic       I_query_hit,
    output logic [9:0] O_food_x,
    output logic [9:0] O_food_y,
    output logic       O_food_valid,
    output logic       O_eat,
    output logic [7:0] O_score,
    output logic       O_forced
);

    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);
    localparam logic [9:0] GRID_MASK = ~10'((1 << GRID_LOG2) - 1);
    localparam logic [9:0] XLO = 10'(X_MIN);
    localparam logic [9:0] XHI = 10'(X_MAX);
    localparam logic [9:0] YLO = 10'(Y_MIN);
    localparam logic [9:0] YHI = 10'(Y_MAX);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRIVE = 3'd1,
        WAIT1 = 3'd2,
        WAIT2 = 3'd3,
        QUERY = 3'd4
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [RW-1:0] retry_q;
    logic          eat;
    logic          accept;
    logic          force_acc;
    logic          retry_inc;

    function automatic logic [9:0] snap(input logic [9:0] v, input logic [9:0] lo,
                                        input logic [9:0] hi);
        logic [9:0] c;
        c = v;
        if (v < lo) c = lo;
        else if (v > hi) c = hi;
        return c & GRID_MASK;
    endfunction

    // Query handshake: O_query_req stays high with a stable candidate until the
    // cycle I_query_ack is sampled high; I_query_hit is meaningful only with ack.
    always_comb begin
        state_d   = state_q;
        eat       = 1'b0;
        accept    = 1'b0;
        force_acc = 1'b0;
        retry_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (I_head_valid && O_food_valid &&
                    I_head_x == O_food_x && I_head_y == O_food_y) begin
                    eat     = 1'b1;
                    state_d = DRIVE;
                end
            end
            DRIVE: state_d = WAIT1;
            WAIT1: state_d = WAIT2;
            WAIT2: state_d = QUERY;
            QUERY: begin
                if (I_query_ack) begin
                    if (!I_query_hit) begin
                        accept = 1'b1;
                    end else if (retry_q < RETRY_LAST) begin
                        retry_inc = 1'b1;
                        state_d   = DRIVE;
                    end else begin
                        accept    = 1'b1;
                        force_acc = 1'b1;
                    end
                    if (accept) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with it.
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            state_q      <= IDLE;
            retry_q      <= '0;
            O_drive      <= 1'b0;
            O_query_req  <= 1'b0;
            O_query_x    <= 10'd0;
            O_query_y    <= 10'd0;
            O_food_x     <= 10'd336;
            O_food_y     <= 10'd320;
            O_food_valid <= 1'b1;
            O_eat        <= 1'b0;
            O_score      <= 8'd0;
            O_forced     <= 1'b0;
        end else begin
            state_q     <= state_d;
            O_eat       <= eat;
            O_drive     <= (state_d == DRIVE);
            O_query_req <= (state_d == QUERY);
            if (eat) begin
                if (O_score != 8'hFF) O_score <= O_score + 8'd1;
                O_food_valid <= 1'b0;
                retry_q      <= '0;
            end
            if (retry_inc) retry_q <= retry_q + 1'b1;
            if (state_q == WAIT2) begin
                O_query_x <= snap(I_rand_x, XLO, XHI);
                O_query_y <= snap(I_rand_y, YLO, YHI);
            end
            if (accept) begin
                O_food_x     <= O_query_x;
                O_food_y     <= O_query_y;
                O_food_valid <= 1'b1;
            end
            if (force_acc) O_forced <= 1'b1;
        end
    end

endmodule

// File: tb/tb_food_manager.sv
// Randomized self-checking bench for food_manager against a rule-level model
// of scoring, candidate clamping/snapping and retry acceptance.
module tb_food_manager;

    logic       clk;
    logic       rst_n;
    logic [9:0] head_x, head_y, rand_x, rand_y;
    logic       head_valid, query_ack, query_hit;
    logic       O_drive, O_query_req, O_food_valid, O_eat, O_forced;
    logic [9:0] O_query_x, O_query_y, O_food_x, O_food_y;
    logic [7:0] O_score;

    food_manager dut (
        .I_clk(clk), .I_rst_n(rst_n),
        .I_head_x(head_x), .I_head_y(head_y), .I_head_valid(head_valid),
        .I_rand_x(rand_x), .I_rand_y(rand_y),
        .O_drive(O_drive), .O_query_req(O_query_req),
        .O_query_x(O_query_x), .O_query_y(O_query_y),
        .I_query_ack(query_ack), .I_query_hit(query_hit),
        .O_food_x(O_food_x), .O_food_y(O_food_y), .O_food_valid(O_food_valid),
        .O_eat(O_eat), .O_score(O_score), .O_forced(O_forced)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int drive_cnt = 0;
    int eat_cnt = 0;
    int req_cnt = 0;

    // model state
    int m_fx, m_fy, m_score, m_cx, m_cy, m_tries;
    bit m_fv, m_forced;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (O_drive === 1'b1) drive_cnt <= drive_cnt + 1;
        if (O_eat === 1'b1) eat_cnt <= eat_cnt + 1;
        if (O_query_req === 1'b1) req_cnt <= req_cnt + 1;
    end

    function automatic int cand(input int v, input int lo, input int hi);
        int c;
        c = (v < lo) ? lo : ((v > hi) ? hi : v);
        return (c / 16) * 16;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_fx = 336; m_fy = 320; m_fv = 1; m_score = 0; m_forced = 0; m_tries = 0;
    endtask

    task automatic do_eat(input int rx, input int ry);
        rand_x = 10'(rx); rand_y = 10'(ry);
        m_cx = cand(rx, 16, 608); m_cy = cand(ry, 16, 448);
        head_x = 10'(m_fx); head_y = 10'(m_fy); head_valid = 1'b1;
        step();
        head_valid = 1'b0;
        m_score = (m_score < 255) ? m_score + 1 : 255;
        m_fv = 0; m_tries = 0;
        total++; if (O_eat !== 1'b1) begin bad++; $display("FAIL eat_pulse got=%b exp=1", O_eat); end
        total++; if (O_score !== 8'(m_score)) begin bad++; $display("FAIL eat_score got=%0d exp=%0d", O_score, m_score); end
        total++; if (O_food_valid !== 1'b0) begin bad++; $display("FAIL eat_valid got=%b exp=0", O_food_valid); end
        total++; if (O_drive !== 1'b1) begin bad++; $display("FAIL eat_drive got=%b exp=1", O_drive); end
    endtask

    task automatic serve(input bit hit, input int delay, input bit poke, output bit done);
        int n;
        logic [9:0] qx, qy;
        int e0;
        n = 0;
        done = 0;
        while (O_query_req !== 1'b1 && n < 20) begin step(); n++; end
        total++;
        if (n >= 20) begin bad++; $display("FAIL query_timeout got=0 exp=1"); return; end
        total++; if (O_query_x !== 10'(m_cx) || O_query_y !== 10'(m_cy)) begin
            bad++; $display("FAIL query_xy got=(%0d,%0d) exp=(%0d,%0d)", O_query_x, O_query_y, m_cx, m_cy);
        end
        qx = O_query_x; qy = O_query_y;
        e0 = eat_cnt;
        for (int i = 0; i < delay; i++) begin
            query_ack = 1'b0; query_hit = 1'($urandom_range(0, 1));
            if (poke) begin head_x = 10'(m_fx); head_y = 10'(m_fy); head_valid = 1'b1; end
            step();
            total++; if (O_query_req !== 1'b1 || O_query_x !== qx || O_query_y !== qy) begin
                bad++; $display("FAIL query_hold cyc%0d got=%b(%0d,%0d) exp=1(%0d,%0d)", i, O_query_req, O_query_x, O_query_y, qx, qy);
            end
            total++; if (O_eat !== 1'b0) begin bad++; $display("FAIL eat_in_wait got=%b exp=0", O_eat); end
        end
        head_valid = 1'b0;
        query_ack = 1'b1; query_hit = hit;
        step();
        query_ack = 1'b0; query_hit = 1'b0;
        m_tries++;
        if (!hit || m_tries == 8) begin
            m_fx = m_cx; m_fy = m_cy; m_fv = 1; done = 1;
            if (hit) m_forced = 1;
        end
        total++; if (O_query_req !== 1'b0) begin bad++; $display("FAIL query_drop got=%b exp=0", O_query_req); end
        total++; if (O_food_valid !== 1'(m_fv)) begin bad++; $display("FAIL ack_valid got=%b exp=%0d", O_food_valid, m_fv); end
        total++; if (O_forced !== 1'(m_forced)) begin bad++; $display("FAIL forced got=%b exp=%0d", O_forced, m_forced); end
        if (done) begin
            total++; if (O_food_x !== 10'(m_fx) || O_food_y !== 10'(m_fy)) begin
                bad++; $display("FAIL food_xy got=(%0d,%0d) exp=(%0d,%0d)", O_food_x, O_food_y, m_fx, m_fy);
            end
        end else begin
            total++; if (O_drive !== 1'b1) begin bad++; $display("FAIL retry_drive got=%b exp=1", O_drive); end
        end
        if (poke) begin
            total++; if (eat_cnt !== e0) begin bad++; $display("FAIL eat_cnt_wait got=%0d exp=%0d", eat_cnt, e0); end
        end
    endtask

    task automatic test_reset();
        total++; if (O_food_x !== 10'd336 || O_food_y !== 10'd320) begin bad++; $display("FAIL reset_food got=(%0d,%0d) exp=(336,320)", O_food_x, O_food_y); end
        total++; if (O_food_valid !== 1'b1) begin bad++; $display("FAIL reset_valid got=%b exp=1", O_food_valid); end
        total++; if (O_score !== 8'd0 || O_forced !== 1'b0) begin bad++; $display("FAIL reset_score got=%0d/%b exp=0/0", O_score, O_forced); end
        total++; if (O_eat !== 1'b0 || O_drive !== 1'b0 || O_query_req !== 1'b0) begin bad++; $display("FAIL reset_strobes got=%b%b%b exp=000", O_eat, O_drive, O_query_req); end
        total++; if (O_query_x !== 10'd0 || O_query_y !== 10'd0) begin bad++; $display("FAIL reset_query got=(%0d,%0d) exp=(0,0)", O_query_x, O_query_y); end
    endtask

    task automatic test_first_eat();
        int c0, c1;
        bit done;
        do_eat(1000, 50);
        c0 = cyc;
        step();
        total++; if (O_eat !== 1'b0 || O_drive !== 1'b0) begin bad++; $display("FAIL pulse_width got=%b%b exp=00", O_eat, O_drive); end
        serve(1'b0, 0, 1'b0, done);
        c1 = cyc;
        total++; if (c1 - c0 !== 4) begin bad++; $display("FAIL latency got=%0d exp=4", c1 - c0); end
    endtask

    task automatic test_retry_once();
        int d0;
        bit done;
        d0 = drive_cnt;
        do_eat(345, 200);
        serve(1'b1, 0, 1'b0, done);
        serve(1'b0, 0, 1'b0, done);
        step();
        total++; if (drive_cnt - d0 !== 2) begin bad++; $display("FAIL retry_once_drives got=%0d exp=2", drive_cnt - d0); end
        total++; if (O_food_x !== 10'd336 || O_food_y !== 10'd192 || O_forced !== 1'b0) begin
            bad++; $display("FAIL retry_once_food got=(%0d,%0d,%b) exp=(336,192,0)", O_food_x, O_food_y, O_forced);
        end
    endtask

    task automatic test_all_hits();
        int d0;
        bit done;
        d0 = drive_cnt;
        done = 0;
        do_eat(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
        for (int k = 0; k < 10 && !done; k++) serve(1'b1, 0, 1'b0, done);
        repeat (5) step();
        total++; if (drive_cnt - d0 !== 8) begin bad++; $display("FAIL all_hits_drives got=%0d exp=8", drive_cnt - d0); end
        total++; if (O_query_req !== 1'b0 || O_food_valid !== 1'b1) begin bad++; $display("FAIL all_hits_idle got=%b%b exp=01", O_query_req, O_food_valid); end
    endtask

    task automatic test_ack_delay();
        bit done;
        int d0, r0;
        do_eat(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
        serve(1'b0, 10, 1'b1, done);
        // stray acks in IDLE must not start anything
        d0 = drive_cnt; r0 = req_cnt;
        query_ack = 1'b1; query_hit = 1'b1;
        repeat (3) step();
        query_ack = 1'b0; query_hit = 1'b0;
        step();
        total++; if (drive_cnt !== d0 || req_cnt !== r0) begin bad++; $display("FAIL idle_ack got=%0d/%0d exp=%0d/%0d", drive_cnt, req_cnt, d0, r0); end
        total++; if (O_food_x !== 10'(m_fx) || O_food_valid !== 1'b1) begin bad++; $display("FAIL idle_ack_food got=%0d/%b exp=%0d/1", O_food_x, O_food_valid, m_fx); end
    endtask

    task automatic test_random();
        bit done;
        int nh, e0;
        for (int it = 0; it < 40; it++) begin
            e0 = eat_cnt;
            head_x = 10'(m_fx ^ 16); head_y = 10'(m_fy); head_valid = 1'b1;
            repeat ($urandom_range(1, 3)) step();
            head_valid = 1'b0;
            step();
            total++; if (eat_cnt !== e0) begin bad++; $display("FAIL miss_no_eat got=%0d exp=%0d", eat_cnt, e0); end
            nh = $urandom_range(0, 9);
            done = 0;
            do_eat(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
            for (int t = 0; t < 10 && !done; t++) serve(t < nh, int'($urandom_range(0, 3)), 1'b0, done);
        end
    endtask

    task automatic test_saturate();
        bit done;
        while (m_score < 255 || eat_cnt < 260) begin
            do_eat(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
            serve(1'b0, 0, 1'b0, done);
            if (eat_cnt > 400) break;
        end
        total++; if (O_score !== 8'd255) begin bad++; $display("FAIL score_sat got=%0d exp=255", O_score); end
    endtask

    task automatic test_reset_mid();
        int d0, r0;
        bit done;
        do_eat(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        model_reset();
        test_reset();
        repeat (2) step();
        d0 = drive_cnt; r0 = req_cnt;
        repeat (15) step();
        total++; if (drive_cnt !== d0 || req_cnt !== r0) begin bad++; $display("FAIL reset_abort got=%0d/%0d exp=%0d/%0d", drive_cnt, req_cnt, d0, r0); end
        do_eat(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
        serve(1'b0, 1, 1'b0, done);
    endtask

    initial begin
        rst_n = 1'b0; head_valid = 1'b0; query_ack = 1'b0; query_hit = 1'b0;
        head_x = '0; head_y = '0; rand_x = '0; rand_y = '0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        model_reset();
        test_reset();
        test_first_eat();
        test_retry_once();
        test_all_hits();
        test_ack_delay();
        test_random();
        test_saturate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
